// File: rtl/timer_intr_source.sv
// Memory-mapped programmable timer. A prescaled counter runs up to a compare value,
// sets a sticky match flag, and can raise a one-cycle interrupt request pulse.
module timer_intr_source #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_sel,
  input  logic        I_we,
  input  logic [2:0]  I_addr,
  input  logic [31:0] I_wdata,
  output logic [31:0] O_rdata,
  output logic        O_intr_rq,
  output logic        O_match
);

  typedef enum logic [2:0] {
    ADDR_CTRL     = 3'd0,
    ADDR_PRESCALE = 3'd1,
    ADDR_COMPARE  = 3'd2,
    ADDR_COUNT    = 3'd3,
    ADDR_STATUS   = 3'd4
  } reg_addr_e;

  logic                  en, auto_reload, irq_en;
  logic [PRESCALE_W-1:0] prescale, pre_cnt;
  logic [WIDTH-1:0]      compare, count;
  logic                  match_flag, intr_rq;

  logic wr, wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic tick, match_evt;

  assign wr          = I_sel && I_we;
  assign wr_ctrl     = wr && (I_addr == ADDR_CTRL);
  assign wr_prescale = wr && (I_addr == ADDR_PRESCALE);
  assign wr_compare  = wr && (I_addr == ADDR_COMPARE);
  assign wr_count    = wr && (I_addr == ADDR_COUNT);
  assign wr_status   = wr && (I_addr == ADDR_STATUS);

  assign tick      = en && (pre_cnt == prescale);
  assign match_evt = tick && (count == compare);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      en          <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      prescale    <= '0;
      compare     <= '1;
      count       <= '0;
      pre_cnt     <= '0;
      match_flag  <= 1'b0;
      intr_rq     <= 1'b0;
    end else begin
      // Control: a CTRL write overrides the one-shot self-disable.
      if (wr_ctrl) begin
        en          <= I_wdata[0];
        auto_reload <= I_wdata[1];
        irq_en      <= I_wdata[2];
      end else if (match_evt && !auto_reload) begin
        en <= 1'b0;
      end

      if (wr_prescale) prescale <= I_wdata[PRESCALE_W-1:0];
      if (wr_compare)  compare  <= I_wdata[WIDTH-1:0];

      // Prescaler restarts on any reconfiguration, on each tick, and while stopped.
      if (!en || tick || wr_ctrl || wr_prescale) pre_cnt <= '0;
      else                                       pre_cnt <= pre_cnt + 1'b1;

      // A bus load of COUNT swallows a coincident tick.
      if (wr_count) begin
        count <= I_wdata[WIDTH-1:0];
      end else if (tick) begin
        if (!match_evt)      count <= count + 1'b1;
        else if (auto_reload) count <= '0;
      end

      // Set beats write-1-to-clear when both land on the same edge.
      if (match_evt)                   match_flag <= 1'b1;
      else if (wr_status && I_wdata[0]) match_flag <= 1'b0;

      intr_rq <= match_evt && irq_en;
    end
  end

  // NOTE: default the read bus first so no path through the case infers a latch.
  always_comb begin
    O_rdata = '0;
    if (I_sel) begin
      case (I_addr)
        ADDR_CTRL:     O_rdata = {29'd0, irq_en, auto_reload, en};
        ADDR_PRESCALE: O_rdata = 32'(prescale);
        ADDR_COMPARE:  O_rdata = 32'(compare);
        ADDR_COUNT:    O_rdata = 32'(count);
        ADDR_STATUS:   O_rdata = {31'd0, match_flag};
        default:       O_rdata = '0;
      endcase
    end
  end

  assign O_intr_rq = intr_rq;
  assign O_match   = match_flag;

endmodule

// File: tb/tb_timer_intr_source.sv
// Directed self-checking bench for timer_intr_source: register reset values,
// auto-reload and one-shot timing, IRQ gating, collisions and async reset.
module tb_timer_intr_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel, we;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  logic        intr_rq, match;

  int checks   = 0;
  int failures = 0;
  logic [31:0] v;

  timer_intr_source dut (
    .I_clk    (clk),
    .I_rst_n  (rst_n),
    .I_sel    (sel),
    .I_we     (we),
    .I_addr   (addr),
    .I_wdata  (wdata),
    .O_rdata  (rdata),
    .O_intr_rq(intr_rq),
    .O_match  (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. Reset values
    rd(3'd0, v); check("rst_ctrl", v, 32'h0);
    rd(3'd1, v); check("rst_prescale", v, 32'h0);
    rd(3'd2, v); check("rst_compare", v, 32'hFFFF_FFFF);
    rd(3'd3, v); check("rst_count", v, 32'h0);
    rd(3'd4, v); check("rst_status", v, 32'h0);
    rd(3'd5, v); check("rst_reserved", v, 32'h0);
    check("rst_intr", {31'd0, intr_rq}, 32'd0);
    check("rst_match", {31'd0, match}, 32'd0);

    // 2. Auto-reload, PRESCALE=0, COMPARE=3: count 0,1,2,3,0 and pulse every 4 cycles
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd7);
    rd(3'd3, v); check("ar_count0", v, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      rd(3'd3, v);
      check($sformatf("ar_count_%0d", k), v, 32'(k % 4));
      check($sformatf("ar_intr_%0d", k), {31'd0, intr_rq}, 32'((k % 4) == 0));
    end
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    check("ar_match_cleared", {31'd0, match}, 32'd0);

    // 3. One-shot, PRESCALE=2, COMPARE=1: single pulse 6 cycles after enable
    wr(3'd1, 32'd2);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd5);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("os_intr_%0d", k), {31'd0, intr_rq}, 32'(k == 6));
    end
    rd(3'd0, v); check("os_ctrl_en_cleared", v, 32'd4);
    rd(3'd3, v); check("os_count_held", v, 32'd1);
    rd(3'd4, v); check("os_status", v, 32'd1);
    wr(3'd4, 32'd1);

    // 4. IRQ_EN=0: match flag sets, no request pulse; write-0 has no effect
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("noirq_intr_%0d", k), {31'd0, intr_rq}, 32'd0);
    end
    rd(3'd4, v); check("noirq_status", v, 32'd1);
    check("noirq_omatch", {31'd0, match}, 32'd1);
    wr(3'd4, 32'd0);
    rd(3'd4, v); check("status_w0_noeffect", v, 32'd1);
    wr(3'd4, 32'd1);
    rd(3'd4, v); check("status_w1c", v, 32'd0);
    check("status_w1c_omatch", {31'd0, match}, 32'd0);

    // 5. Collisions: W1C on the match edge, COUNT write on a tick edge
    wr(3'd2, 32'd3);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd3);                 // enable at E0; match at E4
    repeat (3) @(posedge clk);       // now at E3
    wr(3'd4, 32'd1);                 // lands on E4
    rd(3'd4, v); check("coll_set_wins", v, 32'd1);
    rd(3'd3, v); check("coll_reload", v, 32'd0);
    wr(3'd3, 32'd5);
    rd(3'd3, v); check("coll_count_write", v, 32'd5);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // 6. Async reset mid-pulse with COUNT=2
    wr(3'd2, 32'd2);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd5);                 // one-shot with IRQ; match at E3
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_intr", {31'd0, intr_rq}, 32'd1);
    rd(3'd3, v); check("pre_rst_count", v, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_intr", {31'd0, intr_rq}, 32'd0);
    check("async_rst_match", {31'd0, match}, 32'd0);
    rd(3'd0, v); check("async_rst_ctrl", v, 32'd0);
    rd(3'd2, v); check("async_rst_compare", v, 32'hFFFF_FFFF);
    rd(3'd3, v); check("async_rst_count", v, 32'd0);
    rd(3'd4, v); check("async_rst_status", v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_intr", {31'd0, intr_rq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
